// File: rtl/cpu_pkg.sv
// cpu_pkg: shared CPU widths, opcode encoding and fetch FSM states
package cpu_pkg;
    localparam int ADDR_W     = 16;
    localparam int INSTR_W    = 16;
    localparam int OPCODE_W   = 4;
    localparam int OPCODE_MSB = INSTR_W - 1;
    typedef enum logic [OPCODE_W-1:0] {
        OP_0000, OP_0001, OP_0010, OP_0011, OP_0100, OP_0101, OP_0110, OP_0111,
        OP_1000, OP_1001, OP_1010, OP_1011, OP_1100, OP_1101, OP_1110, OP_1111
    } opcode_e;
    typedef enum logic [1:0] {IDLE, REQ, WAIT, DROP} fetch_state_e;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous prefetch FIFO with flush; head is zero while empty
module fetch_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  logic                   flush_i,
    input  logic [WIDTH-1:0]       wdata_i,
    output logic [WIDTH-1:0]       rdata_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   empty_o,
    output logic                   full_o
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q, rd_q;
    logic [AW:0]      cnt_q;
    logic             do_push, do_pop;
    assign empty_o = cnt_q == '0;
    assign full_o  = cnt_q == (AW+1)'(DEPTH);
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;
    assign rdata_o = empty_o ? '0 : mem_q[rd_q];
    assign count_o = cnt_q;
    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_q] <= wdata_i;
                wr_q        <= wr_q + 1'b1;
            end
            if (do_pop) rd_q <= rd_q + 1'b1;
            cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC, one-outstanding imem fetch FSM and prefetch buffer feeding decode
module instr_fetch_unit #(
    parameter int                 ADDR_W     = 16,
    parameter int                 INSTR_W    = 16,
    parameter int                 FIFO_DEPTH = 4,
    parameter logic [ADDR_W-1:0]  RESET_PC   = '0
) (
    input  logic                          clk,
    input  logic                          rst,
    output logic                          imem_req,
    output logic [ADDR_W-1:0]             imem_addr,
    input  logic                          imem_gnt,
    input  logic                          imem_rvalid,
    input  logic [INSTR_W-1:0]            imem_rdata,
    input  logic                          redirect_valid,
    input  logic [ADDR_W-1:0]             redirect_pc,
    output logic                          instr_valid,
    input  logic                          instr_ready,
    output logic [INSTR_W-1:0]            instr_data,
    output logic [ADDR_W-1:0]             instr_pc,
    output logic [3:0]                    opcode,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
    import cpu_pkg::*;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    fetch_state_e               state_q;
    logic [ADDR_W-1:0]          pc_q;
    logic                       push, pop, empty, full, space_after_push;
    logic [ADDR_W+INSTR_W-1:0]  head;
    logic [CW:0]                occ_after;
    assign push = (state_q == WAIT) & imem_rvalid & ~redirect_valid;
    assign pop  = ~empty & instr_ready & ~redirect_valid;
    assign occ_after = (CW+1)'(fifo_count) + (CW+1)'(1) - (CW+1)'(pop);
    assign space_after_push = occ_after < (CW+1)'(FIFO_DEPTH);
    fetch_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(ADDR_W + INSTR_W)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (redirect_valid),
        .wdata_i ({imem_rdata, pc_q - 1'b1}),
        .rdata_o (head),
        .count_o (fifo_count),
        .empty_o (empty),
        .full_o  (full)
    );
    assign imem_req    = state_q == REQ;
    assign imem_addr   = pc_q;
    assign instr_valid = ~empty;
    assign instr_data  = head[ADDR_W +: INSTR_W];
    assign instr_pc    = head[ADDR_W-1:0];
    assign opcode      = instr_data[INSTR_W-1 -: OPCODE_W];
    // pc advances at grant, so the address of a returning word is pc_q-1
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
        end else if (redirect_valid) begin
            pc_q <= redirect_pc;
            if (state_q == WAIT || state_q == DROP) state_q <= imem_rvalid ? REQ : DROP;
            else state_q <= (state_q == REQ && imem_gnt) ? DROP : REQ;
        end else begin
            case (state_q)
                IDLE: if (!full) state_q <= REQ;
                REQ: if (imem_gnt) begin
                    state_q <= WAIT;
                    pc_q    <= pc_q + 1'b1;
                end
                WAIT: if (imem_rvalid) state_q <= space_after_push ? REQ : IDLE;
                DROP: if (imem_rvalid) state_q <= REQ;
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: random-latency memory, stream model and scenario tasks for instr_fetch_unit
module tb_instr_fetch_unit;
    localparam int DEPTH = 4;
    logic clk = 0, rst, imem_req, imem_gnt, imem_rvalid, redirect_valid, instr_valid, instr_ready;
    logic [15:0] imem_addr, imem_rdata, redirect_pc, instr_data, instr_pc;
    logic [3:0] opcode;
    logic [2:0] fifo_count;
    int checks = 0, failures = 0, proto_err = 0, cyc = 0;
    int gnt_pct = 100, lat_lo = 1, lat_hi = 1;
    bit dead_next = 0, pend = 0;
    int cnt = 0;
    logic [15:0] paddr;
    logic [15:0] got_pc[$], got_data[$], exp_q[$];
    logic [3:0] got_op[$];
    int got_cyc[$];
    logic [15:0] exp_pc = 0;
    logic p_req = 0, p_gnt = 0, p_redir = 0, p_rst = 1, p_valid = 0, p_ready = 0;
    logic [15:0] p_addr = 0, p_data = 0, p_pc = 0;

    instr_fetch_unit dut (
        .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_data(instr_data), .instr_pc(instr_pc), .opcode(opcode), .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] word(input logic [15:0] a);
        return a * 16'h0101 + 16'h1234;
    endfunction

    // instruction memory: random grant, 1 response per grant after lat_lo..lat_hi cycles
    initial begin
        bit rs;
        imem_gnt = 0; imem_rvalid = 0; imem_rdata = 0;
        forever begin
            @(posedge clk);
            rs = rst;
            @(negedge clk);
            imem_gnt = 0; imem_rvalid = 0;
            if (rs) pend = 0;
            if (pend && imem_req && !rs) proto_err++;
            if (pend) begin
                if (cnt <= 1) begin
                    imem_rvalid = 1;
                    imem_rdata = dead_next ? 16'hDEAD : word(paddr);
                    dead_next = 0;
                    pend = 0;
                end else cnt--;
            end else if (imem_req && $urandom_range(0, 99) < gnt_pct) begin
                imem_gnt = 1; pend = 1; paddr = imem_addr;
                cnt = $urandom_range(lat_lo, lat_hi);
            end
        end
    end

    // stream model: after reset/redirect the accepted stream is consecutive addresses holding word(addr)
    initial begin
        forever begin
            @(negedge clk); #3; cyc++;
            if (!p_rst) begin
                if (p_req && !p_gnt && !p_redir && (!imem_req || imem_addr !== p_addr)) proto_err++;
                if (p_valid && !p_ready && !p_redir && (!instr_valid || instr_data !== p_data || instr_pc !== p_pc)) proto_err++;
                if (fifo_count > DEPTH || instr_valid !== (fifo_count != 0) || opcode !== instr_data[15:12]) proto_err++;
            end
            if (rst) exp_pc = 16'h0;
            else if (redirect_valid) exp_pc = redirect_pc;
            else if (instr_valid && instr_ready) begin
                got_pc.push_back(instr_pc); got_data.push_back(instr_data); got_op.push_back(opcode);
                got_cyc.push_back(cyc); exp_q.push_back(exp_pc);
                exp_pc++;
            end
            p_req = imem_req; p_gnt = imem_gnt; p_redir = redirect_valid; p_rst = rst;
            p_valid = instr_valid; p_ready = instr_ready; p_addr = imem_addr; p_data = instr_data; p_pc = instr_pc;
        end
    end

    task automatic do_reset(input logic rdy);
        @(negedge clk);
        rst = 1; redirect_valid = 0; instr_ready = rdy; dead_next = 0;
        repeat (2) @(negedge clk);
        got_pc.delete(); got_data.delete(); got_op.delete(); got_cyc.delete(); exp_q.delete();
        rst = 0;
    endtask

    task automatic wait_accepts(input int n, input int budget, output bit ok);
        for (int i = 0; i < budget && got_pc.size() < n; i++) @(negedge clk);
        ok = got_pc.size() >= n;
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        #1;
        checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL reset_req: got %b want 0", imem_req); end
        checks++; if (imem_addr !== 16'h0) begin failures++; $display("FAIL reset_addr: got %h want 0000", imem_addr); end
        checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b want 0", instr_valid); end
        checks++; if (fifo_count !== 3'd0) begin failures++; $display("FAIL reset_count: got %0d want 0", fifo_count); end
        checks++; if ({instr_data, instr_pc, opcode} !== 36'h0) begin failures++;
            $display("FAIL reset_outputs: got data=%h pc=%h op=%h want zeros", instr_data, instr_pc, opcode); end
    endtask

    task automatic test_basic;
        bit ok;
        logic [15:0] w;
        gnt_pct = 100; lat_lo = 1; lat_hi = 1;
        do_reset(1);
        wait_accepts(4, 40, ok);
        checks++; if (!ok) begin failures++; $display("FAIL basic_timeout: got %0d accepts want 4", got_pc.size()); return; end
        for (int i = 0; i < 4; i++) begin
            w = word(16'(i));
            checks++;
            if (got_pc[i] !== 16'(i) || got_data[i] !== w || got_op[i] !== w[15:12]) begin failures++;
                $display("FAIL basic_instr[%0d]: got pc=%h data=%h op=%h want pc=%h data=%h op=%h", i, got_pc[i], got_data[i], got_op[i], 16'(i), w, w[15:12]); end
        end
        checks++; if (got_data[0] !== 16'h1234 || got_op[0] !== 4'h1) begin failures++;
            $display("FAIL basic_opcode: got data=%h op=%h want 1234/1", got_data[0], got_op[0]); end
        for (int i = 1; i < 4; i++) begin
            checks++; if (got_cyc[i] - got_cyc[i-1] !== 2) begin failures++;
                $display("FAIL basic_rate[%0d]: got gap %0d want 2", i, got_cyc[i] - got_cyc[i-1]); end
        end
    endtask

    task automatic test_backpressure;
        bit ok;
        do_reset(0);
        repeat (20) @(negedge clk);
        #1;
        checks++; if (fifo_count !== 3'd4 || imem_req !== 1'b0 || instr_valid !== 1'b1 || instr_pc !== 16'h0) begin failures++;
            $display("FAIL bp_full: got count=%0d req=%b valid=%b pc=%h want 4/0/1/0000", fifo_count, imem_req, instr_valid, instr_pc); end
        instr_ready = 1;
        wait_accepts(6, 60, ok);
        checks++; if (!ok) begin failures++; $display("FAIL bp_timeout: got %0d accepts want 6", got_pc.size()); return; end
        for (int i = 0; i < 6; i++) begin
            checks++; if (got_pc[i] !== 16'(i) || got_data[i] !== word(16'(i))) begin failures++;
                $display("FAIL bp_order[%0d]: got pc=%h data=%h want pc=%h data=%h", i, got_pc[i], got_data[i], 16'(i), word(16'(i))); end
        end
    endtask

    task automatic test_redirect_wait;
        bit ok, found = 0;
        lat_lo = 3; lat_hi = 3;
        do_reset(0);
        for (int i = 0; i < 60 && !found; i++) begin
            @(negedge clk); #1;
            found = fifo_count == 3'd2 && !imem_req && pend && cnt > 1;
        end
        checks++; if (!found) begin failures++; $display("FAIL rw_setup: got no WAIT with 2 buffered want found"); return; end
        dead_next = 1; redirect_valid = 1; redirect_pc = 16'h0040;
        @(negedge clk);
        redirect_valid = 0;
        #1;
        checks++; if (instr_valid !== 1'b0 || fifo_count !== 3'd0 || imem_req !== 1'b0) begin failures++;
            $display("FAIL rw_flush: got valid=%b count=%0d req=%b want 0/0/0", instr_valid, fifo_count, imem_req); end
        instr_ready = 1;
        wait_accepts(2, 40, ok);
        checks++; if (!ok) begin failures++; $display("FAIL rw_timeout: got %0d accepts want 2", got_pc.size()); return; end
        checks++; if (got_pc[0] !== 16'h0040 || got_data[0] !== word(16'h0040) || got_pc[1] !== 16'h0041) begin failures++;
            $display("FAIL rw_target: got pc=%h data=%h next=%h want 0040/%h/0041", got_pc[0], got_data[0], got_pc[1], word(16'h0040)); end
    endtask

    task automatic test_redirect_coincident;
        bit ok, found = 0;
        lat_lo = 2; lat_hi = 2;
        do_reset(0);
        for (int i = 0; i < 60 && !found; i++) begin
            @(negedge clk); #1;
            found = imem_rvalid && instr_valid;
        end
        checks++; if (!found) begin failures++; $display("FAIL rc_setup: got no rvalid with valid head want found"); return; end
        redirect_valid = 1; redirect_pc = 16'h1230; instr_ready = 1;
        @(negedge clk);
        redirect_valid = 0; instr_ready = 0;
        #1;
        checks++; if (fifo_count !== 3'd0 || instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 16'h1230) begin failures++;
            $display("FAIL rc_state: got count=%0d valid=%b req=%b addr=%h want 0/0/1/1230", fifo_count, instr_valid, imem_req, imem_addr); end
        instr_ready = 1;
        wait_accepts(1, 40, ok);
        checks++; if (!ok || got_pc[0] !== 16'h1230 || got_data[0] !== word(16'h1230)) begin failures++;
            $display("FAIL rc_first: got n=%0d pc=%h want pc=1230", got_pc.size(), ok ? got_pc[0] : 16'hxxxx); end
    endtask

    task automatic test_wrap;
        bit ok;
        lat_lo = 1; lat_hi = 1;
        do_reset(1);
        redirect_valid = 1; redirect_pc = 16'hFFFF;
        @(negedge clk);
        redirect_valid = 0;
        wait_accepts(3, 40, ok);
        checks++; if (!ok) begin failures++; $display("FAIL wrap_timeout: got %0d accepts want 3", got_pc.size()); return; end
        checks++; if (got_pc[0] !== 16'hFFFF || got_pc[1] !== 16'h0000 || got_pc[2] !== 16'h0001) begin failures++;
            $display("FAIL wrap_seq: got %h %h %h want ffff 0000 0001", got_pc[0], got_pc[1], got_pc[2]); end
    endtask

    task automatic test_reset_midop;
        bit ok, found = 0;
        lat_lo = 3; lat_hi = 3;
        do_reset(0);
        for (int i = 0; i < 80 && !found; i++) begin
            @(negedge clk); #1;
            found = fifo_count == 3'd3 && !imem_req && pend;
        end
        checks++; if (!found) begin failures++; $display("FAIL rm_setup: got no WAIT with 3 buffered want found"); return; end
        rst = 1;
        @(negedge clk); #1;
        checks++; if (instr_valid !== 1'b0 || fifo_count !== 3'd0 || imem_req !== 1'b0) begin failures++;
            $display("FAIL rm_state: got valid=%b count=%0d req=%b want 0/0/0", instr_valid, fifo_count, imem_req); end
        rst = 0;
        found = 0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk); #1;
            found = imem_req;
        end
        checks++; if (!found || imem_addr !== 16'h0) begin failures++;
            $display("FAIL rm_addr: got req=%b addr=%h want 1/0000", found, imem_addr); end
        instr_ready = 1;
        wait_accepts(2, 40, ok);
        checks++; if (!ok || got_pc[0] !== 16'h0 || got_data[0] !== word(16'h0) || got_pc[1] !== 16'h1) begin failures++;
            $display("FAIL rm_stream: got n=%0d want pc 0000,0001", got_pc.size()); end
    endtask

    task automatic test_random;
        int acc = 0;
        logic [15:0] p, d, e;
        logic [3:0] o;
        gnt_pct = 60; lat_lo = 1; lat_hi = 4;
        do_reset(0);
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            instr_ready = $urandom_range(0, 9) < 7;
            redirect_valid = $urandom_range(0, 99) < 2;
            redirect_pc = $urandom_range(0, 3) == 0 ? 16'hFFFE : 16'($urandom);
            while (got_pc.size() > 0) begin
                p = got_pc.pop_front(); d = got_data.pop_front(); o = got_op.pop_front(); e = exp_q.pop_front();
                void'(got_cyc.pop_front());
                acc++;
                checks++; if (p !== e || d !== word(e) || o !== word(e) >> 12) begin failures++;
                    $display("FAIL rand_instr: got pc=%h data=%h op=%h want pc=%h data=%h", p, d, o, e, word(e)); end
            end
        end
        redirect_valid = 0;
        checks++; if (acc < 200) begin failures++; $display("FAIL rand_progress: got %0d accepts want >=200", acc); end
        checks++; if (proto_err !== 0) begin failures++; $display("FAIL protocol: got %0d violations want 0", proto_err); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish want finish before 500000");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1; instr_ready = 0; redirect_valid = 0; redirect_pc = 0;
        test_reset();
        test_basic();
        test_backpressure();
        test_redirect_wait();
        test_redirect_coincident();
        test_wrap();
        test_reset_midop();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
